wrr_credit_arbiter: RTL and testbench
=====================================

WRR_CREDIT_ARBITER -- requirements
Module: wrr_credit_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 32: number of requesters, 2..64.
REQ-002 SHALL have parameter WEIGHT_W, default 4: per-requester weight and credit width.
REQ-003 SHALL have derived localparam ID_W = $clog2(N_REQ): grant index width (5 at default).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port req, input, N_REQ: request vector; bit i is requester i.
REQ-007 SHALL have port weight, input, N_REQ*WEIGHT_W: packed weights; slice i is requester i.
REQ-008 SHALL have port ack, input, 1: the granted requester accepts the grant.
REQ-009 SHALL have port gnt_w, output, N_REQ: one-hot grant vector, registered.
REQ-010 SHALL have port gnt_id, output, ID_W: index of the granted requester, registered.
REQ-011 SHALL have port gnt_valid, output, 1: a grant is outstanding, registered.
REQ-012 SHALL have port round_start, output, 1: one-cycle pulse when credits reload.

Function
REQ-013 SHALL implement a 2-state FSM, IDLE and GRANT.
REQ-014 SHALL define eligible[i] = req[i] & (credit[i] != 0).
REQ-015 SHALL define active[i] = req[i] & (weight[i] != 0).
REQ-016 SHALL ignore requesters with weight 0; they are never granted.
REQ-017 IDLE, eligible != 0: SHALL pick the first eligible index searching upward from ptr, wrapping at N_REQ-1 to 0.
REQ-018 IDLE, eligible != 0: SHALL register gnt_w, gnt_id and gnt_valid=1 at that edge and move to GRANT (one-cycle req-to-grant latency).
REQ-019 IDLE, eligible == 0 and active != 0: SHALL load credit[i] = weight[i] for every i.
REQ-020 On that reload, SHALL pulse round_start for one cycle, issue no grant that cycle, and stay in IDLE.
REQ-021 IDLE, active == 0: SHALL hold state, with outputs at 0.
REQ-022 GRANT, ack=1 at an edge: SHALL decrement credit[gnt_id], clear gnt_w, gnt_valid and gnt_id, and return to IDLE.
REQ-023 Because of REQ-022, SHALL insert exactly one idle cycle between grants.
REQ-024 Pointer on ack: ptr = gnt_id if the decremented credit != 0, else ptr = (gnt_id+1) mod N_REQ; the holder keeps priority until its credit is exhausted.
REQ-025 GRANT, ack=0 and req[gnt_id]=0: SHALL abort the grant (clear outputs, go to IDLE) with credit and ptr unchanged.
REQ-026 GRANT, ack=1 and req[gnt_id]=0 in the same cycle: SHALL treat it as an ack (REQ-022).
REQ-027 SHALL ignore ack when gnt_valid=0.
REQ-028 SHALL sample weight only on reload; changes to weight take effect at the next round_start.
REQ-029 SHALL never decrement a credit below 0 or let it wrap.
REQ-030 SHALL keep gnt_w at most one-hot, and equal to (1 << gnt_id) whenever gnt_valid=1.

Reset
REQ-031 rst=1 at a posedge SHALL force: state IDLE, ptr 0, all credits 0, gnt_w 0, gnt_id 0, gnt_valid 0, round_start 0.
REQ-032 rst SHALL take precedence over ack and req, including mid-grant; no credit update occurs in that cycle.
REQ-033 After reset, the first arbitration with active != 0 SHALL be a reload, because all credits are 0.

Structure
REQ-034 SHALL provide package wrr_arbiter_pkg holding: state enum (IDLE, GRANT), default N_REQ and WEIGHT_W constants, and a credit type.
REQ-035 SHALL provide sub-module wrr_rr_picker: combinational rotate-priority find-first (inputs: vector, start index; outputs: one-hot, index, found).
REQ-036 SHALL keep all other state (FSM, credits, ptr, output registers) in wrr_credit_arbiter.

Verification (N_REQ=4, WEIGHT_W=4, ack driven 1 cycle after every grant)
REQ-037 Weight-ratio scenario: weights {w0=1,w1=2,w2=3,w3=0}, req=4'b1111 constant -> round_start, then gnt_id 0,1,1,2,2,2, then round_start again and the sequence repeats; requester 3 never granted.
REQ-038 Single-requester scenario: req=4'b0100, w2=15 -> 15 grants to id 2, then round_start, then grants continue.
REQ-039 Withdrawal scenario: grant to id 1 outstanding, req[1] dropped with ack=0 -> gnt_valid=0 next edge; credit[1] unchanged; re-raising req[1] regrants id 1.
REQ-040 Reset-mid-grant scenario: rst=1 for 1 cycle while gnt_valid=1 and ack=1 -> all outputs 0, and the next arbitration is a reload.
REQ-041 Weight-change scenario: w0 changed 1->4 mid-round -> the current round is still served with w0=1; 4 grants to id 0 follow the next round_start.
REQ-042 Wrap scenario: ptr=3, req=4'b0011 -> grant goes to id 0, then id 1.

Source files
------------

// File: rtl/wrr_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wrr_arbiter_pkg : shared types and defaults for the WRR credit arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package wrr_arbiter_pkg;

  localparam int DEF_N_REQ    = 32;
  localparam int DEF_WEIGHT_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef logic [DEF_WEIGHT_W-1:0] credit_t;

  // Modulo-n increment without a divider.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wrr_credit_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wrr_credit_arbiter_if : request/weight/ack and grant bundle of the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface wrr_credit_arbiter_if #(
  parameter int N_REQ    = wrr_arbiter_pkg::DEF_N_REQ,
  parameter int WEIGHT_W = wrr_arbiter_pkg::DEF_WEIGHT_W
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]          req;
  logic [N_REQ*WEIGHT_W-1:0] weight;
  logic                      ack;
  logic [N_REQ-1:0]          gnt_w;
  logic [ID_W-1:0]           gnt_id;
  logic                      gnt_valid;
  logic                      round_start;

  modport master (
    output req, weight, ack,
    input  gnt_w, gnt_id, gnt_valid, round_start
  );

  modport slave (
    input  req, weight, ack,
    output gnt_w, gnt_id, gnt_valid, round_start
  );
endinterface
`default_nettype wire

// File: rtl/wrr_rr_picker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wrr_rr_picker : rotate-priority find-first, searching upward from i_start
// Rev 1.0
// ---------------------------------------------------------------------------
module wrr_rr_picker #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  wire logic [N-1:0]   i_vec,
  input  wire logic [IDW-1:0] i_start,
  output logic      [N-1:0]   o_onehot,
  output logic      [IDW-1:0] o_idx,
  output logic                o_found
);

  always_comb begin
    int j;
    j        = 0;
    o_onehot = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(i_start) + k) % N;
      if (!o_found && i_vec[IDW'(j)]) begin
        o_found              = 1'b1;
        o_idx                = IDW'(j);
        o_onehot[IDW'(j)]    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wrr_credit_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wrr_credit_arbiter : weighted round-robin arbiter with per-requester credits
// Rev 1.0
// ---------------------------------------------------------------------------
module wrr_credit_arbiter #(
  parameter int N_REQ    = wrr_arbiter_pkg::DEF_N_REQ,
  parameter int WEIGHT_W = wrr_arbiter_pkg::DEF_WEIGHT_W
) (
  input wire logic           clk,
  input wire logic           rst,
  wrr_credit_arbiter_if.slave bus
);
  import wrr_arbiter_pkg::*;

  localparam int        ID_W     = $clog2(N_REQ);
  localparam logic [0:0] ST_IDLE  = 1'(IDLE);
  localparam logic [0:0] ST_GRANT = 1'(GRANT);

  logic [0:0]          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] credit_q [N_REQ];
  logic [WEIGHT_W-1:0] credit_d [N_REQ];
  logic [N_REQ-1:0]    gnt_w_q, gnt_w_d;
  logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
  logic                gnt_valid_q, gnt_valid_d;
  logic                round_start_q, round_start_d;

  logic [N_REQ-1:0]    w_eligible, w_active, w_pick_onehot;
  logic [ID_W-1:0]     w_pick_idx;
  logic                w_pick_found;
  logic [WEIGHT_W-1:0] w_cur_credit;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign w_eligible[i] = bus.req[i] & (credit_q[i] != '0);
    assign w_active[i]   = bus.req[i] & (bus.weight[i*WEIGHT_W +: WEIGHT_W] != '0);
  end

  wrr_rr_picker #(.N(N_REQ)) u_picker (
    .i_vec    (w_eligible),
    .i_start  (ptr_q),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_found  (w_pick_found)
  );

  assign w_cur_credit = credit_q[gnt_id_q];

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    credit_d      = credit_q;
    gnt_w_d       = gnt_w_q;
    gnt_id_d      = gnt_id_q;
    gnt_valid_d   = gnt_valid_q;
    round_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_pick_found) begin
          gnt_w_d     = w_pick_onehot;
          gnt_id_d    = w_pick_idx;
          gnt_valid_d = 1'b1;
          state_d     = ST_GRANT;
        end else if (|w_active) begin
          // Round exhausted: every credit reloads, even for idle requesters.
          for (int i = 0; i < N_REQ; i++) begin
            credit_d[i] = bus.weight[i*WEIGHT_W +: WEIGHT_W];
          end
          round_start_d = 1'b1;
        end
      end
      ST_GRANT: begin
        if (bus.ack) begin
          if (w_cur_credit != '0) begin
            credit_d[gnt_id_q] = w_cur_credit - WEIGHT_W'(1);
          end
          // Holder keeps priority while it still has credit left after this ack.
          ptr_d       = (w_cur_credit > WEIGHT_W'(1)) ? gnt_id_q
                                                      : ID_W'(wrap_inc(32'(gnt_id_q), N_REQ));
          gnt_w_d     = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (!bus.req[gnt_id_q]) begin
          gnt_w_d     = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      for (int i = 0; i < N_REQ; i++) credit_q[i] <= '0;
      gnt_w_q       <= '0;
      gnt_id_q      <= '0;
      gnt_valid_q   <= 1'b0;
      round_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      credit_q      <= credit_d;
      gnt_w_q       <= gnt_w_d;
      gnt_id_q      <= gnt_id_d;
      gnt_valid_q   <= gnt_valid_d;
      round_start_q <= round_start_d;
    end
  end

  assign bus.gnt_w       = gnt_w_q;
  assign bus.gnt_id      = gnt_id_q;
  assign bus.gnt_valid   = gnt_valid_q;
  assign bus.round_start = round_start_q;

endmodule
`default_nettype wire

// File: tb/tb_wrr_credit_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wrr_credit_arbiter : directed scenarios plus random traffic vs a credit model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_wrr_credit_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wrr_credit_arbiter_if #(.N_REQ(N), .WEIGHT_W(WW)) bus ();

  wrr_credit_arbiter #(.N_REQ(N), .WEIGHT_W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: credits per requester, search start, outstanding grant.
  int m_credit [N];
  int m_ptr;
  bit m_busy;
  int m_gid;
  bit m_rs;

  bit auto_ack;
  bit prev_valid;
  int obs_q[$];
  int rs_count;
  int pat6 [6] = '{0, 1, 1, 2, 2, 2};
  int pat7 [7] = '{0, 1, 0, 0, 0, 0, 1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int wslice(input logic [N*WW-1:0] w, input int i);
    return int'(w[i*WW +: WW]);
  endfunction

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return ((int'(v) >> i) & 1) == 1;
  endfunction

  task automatic model_step(input bit r, input logic [N-1:0] rq,
                            input logic [N*WW-1:0] w, input bit a);
    int  found;
    bit  any;
    if (r) begin
      foreach (m_credit[i]) m_credit[i] = 0;
      m_ptr = 0; m_busy = 0; m_gid = 0; m_rs = 0;
      return;
    end
    m_rs = 0;
    if (m_busy) begin
      if (a) begin
        if (m_credit[m_gid] > 0) m_credit[m_gid]--;
        m_ptr  = (m_credit[m_gid] != 0) ? m_gid : (m_gid + 1) % N;
        m_busy = 0;
        m_gid  = 0;
      end else if (!bit_of(rq, m_gid)) begin
        m_busy = 0;
        m_gid  = 0;
      end
    end else begin
      found = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (found < 0 && bit_of(rq, j) && m_credit[j] > 0) found = j;
      end
      if (found >= 0) begin
        m_busy = 1;
        m_gid  = found;
      end else begin
        any = 0;
        for (int i = 0; i < N; i++) if (bit_of(rq, i) && wslice(w, i) > 0) any = 1;
        if (any) begin
          for (int i = 0; i < N; i++) m_credit[i] = wslice(w, i);
          m_rs = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(rst, bus.req, bus.weight, bus.ack);
    #1;
    chk("gnt_valid",   64'(bus.gnt_valid),   64'(m_busy));
    chk("gnt_id",      64'(bus.gnt_id),      m_busy ? 64'(m_gid) : 64'd0);
    chk("gnt_w",       64'(bus.gnt_w),       m_busy ? (64'd1 << m_gid) : 64'd0);
    chk("round_start", 64'(bus.round_start), 64'(m_rs));
    if (bus.gnt_valid && !prev_valid) obs_q.push_back(int'(bus.gnt_id));
    prev_valid = bus.gnt_valid;
    if (bus.round_start) rs_count++;
    if (auto_ack) bus.ack = m_busy;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.ack = 1'b0;
    step();
    rst = 1'b0;
    obs_q.delete();
    rs_count = 0;
  endtask

  initial begin
    int bad;
    logic [N*WW-1:0] wtmp;

    rst = 1'b1; bus.req = '0; bus.weight = '0; bus.ack = 1'b0; auto_ack = 1'b0;
    prev_valid = 1'b0; rs_count = 0;
    step(); step();
    chk("rst_gnt_valid",   64'(bus.gnt_valid),   64'd0);
    chk("rst_gnt_w",       64'(bus.gnt_w),       64'd0);
    chk("rst_round_start", 64'(bus.round_start), 64'd0);
    rst = 1'b0;

    // Only a zero-weight requester: nothing happens.
    bus.req = 4'b0001;
    step(); step();

    // Weight ratio 1:2:3:0 with all requesting.
    bus.weight = {4'd0, 4'd3, 4'd2, 4'd1};
    bus.req    = 4'b1111;
    auto_ack   = 1'b1;
    obs_q.delete(); rs_count = 0;
    repeat (26) step();
    chk("ratio_ngrants", 64'(obs_q.size()), 64'd12);
    chk("ratio_rounds",  64'(rs_count),     64'd2);
    if (obs_q.size() >= 12)
      for (int i = 0; i < 12; i++) chk("ratio_seq", 64'(obs_q[i]), 64'(pat6[i % 6]));

    // Single requester with weight 15.
    do_reset();
    bus.req    = 4'b0100;
    bus.weight = {4'd0, 4'd15, 4'd0, 4'd0};
    repeat (33) step();
    chk("single_ngrants", 64'(obs_q.size()), 64'd16);
    chk("single_rounds",  64'(rs_count),     64'd2);
    bad = 0;
    foreach (obs_q[i]) if (obs_q[i] != 2) bad++;
    chk("single_ids", 64'(bad), 64'd0);

    // Withdrawal of an outstanding grant keeps its credit.
    auto_ack = 1'b0;
    do_reset();
    bus.weight = {4'd1, 4'd1, 4'd1, 4'd1};
    bus.req    = 4'b0010;
    step(); step();
    chk("wd_granted", 64'(bus.gnt_id), 64'd1);
    bus.req = 4'b0000;
    step();
    chk("wd_aborted", 64'(bus.gnt_valid), 64'd0);
    step();
    bus.req = 4'b0010;
    step();
    chk("wd_regrant_valid", 64'(bus.gnt_valid),   64'd1);
    chk("wd_regrant_id",    64'(bus.gnt_id),      64'd1);
    chk("wd_no_reload",     64'(bus.round_start), 64'd0);
    bus.ack = 1'b1; step(); bus.ack = 1'b0;

    // Reset while a grant is outstanding and acked.
    do_reset();
    bus.req = 4'b0011;
    step(); step();
    bus.ack = 1'b1; rst = 1'b1;
    step();
    chk("rmid_valid", 64'(bus.gnt_valid), 64'd0);
    chk("rmid_gnt_w", 64'(bus.gnt_w),     64'd0);
    rst = 1'b0; bus.ack = 1'b0;
    step();
    chk("rmid_reload", 64'(bus.round_start), 64'd1);
    step();
    chk("rmid_first", 64'(bus.gnt_id), 64'd0);

    // Weight change mid-round takes effect at the next reload.
    do_reset();
    auto_ack   = 1'b1;
    bus.weight = {4'd0, 4'd0, 4'd1, 4'd1};
    bus.req    = 4'b0011;
    step(); step();
    bus.weight = {4'd0, 4'd0, 4'd1, 4'd4};
    repeat (13) step();
    chk("wchg_ngrants", 64'(obs_q.size()), 64'd7);
    if (obs_q.size() >= 7)
      for (int i = 0; i < 7; i++) chk("wchg_seq", 64'(obs_q[i]), 64'(pat7[i]));

    // Pointer wrap from 3 to 0.
    auto_ack = 1'b0;
    do_reset();
    bus.weight = {4'd2, 4'd0, 4'd1, 4'd1};
    bus.req    = 4'b1000;
    step(); step();
    bus.ack = 1'b1; step(); bus.ack = 1'b0;
    bus.req = 4'b0011;
    step();
    chk("wrap_first", 64'(bus.gnt_id), 64'd0);
    bus.ack = 1'b1; step(); bus.ack = 1'b0;
    step();
    chk("wrap_second", 64'(bus.gnt_id), 64'd1);
    bus.ack = 1'b1; step(); bus.ack = 1'b0;

    // Random traffic, weights, acks and occasional resets.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      bus.req = 4'($urandom());
      if ($urandom_range(0, 15) == 0) begin
        for (int i = 0; i < N; i++) wtmp[i*WW +: WW] = 4'($urandom_range(0, 3));
        bus.weight = wtmp;
      end
      bus.ack = ($urandom_range(0, 9) < 6);
      rst     = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
